// File: rtl/id_issue_stage.sv
// id_issue_stage: decode-and-issue stage feeding the ID->EX pipeline register.
//
// Holds the IF->ID instruction latch, decodes a MIPS-style 32-bit instruction,
// reads a 32x32 register file written back from WB, and sign-extends the
// immediate. A load-use hazard against the instruction in EX stalls fetch and
// issues a bubble.
//
// Configuration macro: ID_WB_BYPASS_EN
//   defined   - a WB write to a register being read is visible on the read port
//               in the same cycle (write-through).
//   undefined - reads return the pre-write value.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_instr, if_valid  instruction from fetch and its valid flag
//   flush               branch redirect; invalidates the instruction in ID
//   ex_mem_read, ex_rd  load flag and destination of the instruction in EX
//   wb_reg_write, wb_rd, wb_data  register-file writeback
//   opcode, rd, imm     decoded fields to ID->EX
//   rs_data, rt_data, rd_data  register-file reads at rs, rt, rd fields
//   mem_read, mem_write, reg_write  control to ID->EX
//   stall               hold fetch PC and if_instr this cycle
module id_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [5:0]  opcode,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] rd_data,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        stall
);

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpAddi  = 6'h08;

    logic [31:0] instr_q, instr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [5:0]  f_op;
    logic [4:0]  f_rs, f_rt, f_rdf;
    logic        hazard;
    logic        rt_used;
    logic        wb_en;

    assign f_op  = instr_q[31:26];
    assign f_rs  = instr_q[25:21];
    assign f_rt  = instr_q[20:16];
    assign f_rdf = instr_q[15:11];
    assign wb_en = wb_reg_write && (wb_rd != 5'd0);

    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        logic [31:0] val;
        val = (idx == 5'd0) ? 32'd0 : rf_q[idx];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && (wb_rd == idx)) val = wb_data;
`endif
        return val;
    endfunction

    assign rt_used = (f_op == OpRType) || (f_op == OpSw);
    assign hazard  = id_valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                     ((ex_rd == f_rs) || (rt_used && (ex_rd == f_rt)));
    assign stall   = hazard;

    // Latch next state: flush beats stall, stall holds.
    always_comb begin
        instr_d    = instr_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (!hazard) begin
            instr_d    = if_instr;
            id_valid_d = if_valid;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en) rf_d[wb_rd] = wb_data;
    end

    // Whole register file clears in one reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= 32'd0;
            id_valid_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            instr_q    <= instr_d;
            id_valid_q <= id_valid_d;
            rf_q       <= rf_d;
        end
    end

    always_comb begin
        rs_data   = rf_read(f_rs);
        rt_data   = rf_read(f_rt);
        rd_data   = rf_read(f_rdf);
        imm       = {{16{instr_q[15]}}, instr_q[15:0]};
        opcode    = 6'd0;
        rd        = 5'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        if (id_valid_q && !hazard) begin
            opcode = f_op;
            case (f_op)
                OpRType: begin
                    reg_write = 1'b1;
                    rd        = f_rdf;
                end
                OpLw: begin
                    mem_read  = 1'b1;
                    reg_write = 1'b1;
                    rd        = f_rt;
                end
                OpSw:    mem_write = 1'b1;
                OpAddi: begin
                    reg_write = 1'b1;
                    rd        = f_rt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  opcode;
    logic [31:0] rs_data, rt_data, rd_data, imm;
    logic [4:0]  rd;
    logic        mem_read, mem_write, reg_write, stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_issue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .flush        (flush),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .opcode       (opcode),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .rd_data      (rd_data),
        .rd           (rd),
        .imm          (imm),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .stall        (stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic check_ctl(input string tag, input logic [5:0] e_op, input logic [4:0] e_rd,
                             input logic e_mr, input logic e_mw, input logic e_rw,
                             input logic e_st);
        check({tag, ".opcode"}, {26'd0, opcode}, {26'd0, e_op});
        check({tag, ".rd"}, {27'd0, rd}, {27'd0, e_rd});
        check({tag, ".mem_read"}, {31'd0, mem_read}, {31'd0, e_mr});
        check({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, e_mw});
        check({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, e_rw});
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, e_st});
    endtask

    initial begin
        reset = 1'b1; if_instr = 32'd0; if_valid = 1'b0; flush = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        repeat (2) tick();
        reset = 1'b0;
        settle();
        check_ctl("reset", 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.imm", imm, 32'd0);
        check("reset.rs_data", rs_data, 32'd0);

        // Preload r1 and r7 through writeback.
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0100;
        tick();
        wb_rd = 5'd7; wb_data = 32'h1111_1111;
        tick();
        wb_reg_write = 1'b0;
        // LW r2,4(r1)
        if_instr = 32'h8C22_0004; if_valid = 1'b1;
        tick();
        // ADD r3,r2,r3 fetched behind the LW
        if_instr = 32'h0043_1820;
        settle();
        check_ctl("lw", 6'h23, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        check("lw.imm", imm, 32'h4);
        check("lw.rs_data", rs_data, 32'h100);

        tick();
        // LW now in EX: load-use on rs=2
        ex_mem_read = 1'b1; ex_rd = 5'd2;
        if_instr = 32'h2085_FFFF;
        settle();
        check_ctl("lu_stall", 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        tick();
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        settle();
        check_ctl("add_issue", 6'h00, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);

        tick();
        // ADDI r5,r4,-1 with a load to r5 in EX: rt unused, no stall
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        if_instr = 32'h20E8_0000;  // ADDI r8,r7,0
        settle();
        check_ctl("addi", 6'h08, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        check("addi.imm", imm, 32'hFFFF_FFFF);

        tick();
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
        if_instr = 32'h2009_0005;  // ADDI r9,r0,5
        settle();
`ifdef ID_WB_BYPASS_EN
        check("wb_same_cycle.rs_data", rs_data, 32'hDEAD_BEEF);
`else
        check("wb_same_cycle.rs_data", rs_data, 32'h1111_1111);
`endif
        check("wb_same_cycle.rt_data", rt_data, 32'd0);

        tick();
        // Write to r0 must be ignored.
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        if_instr = 32'hAC43_0008;  // SW r3,8(r2)
        settle();
        check("r0_write.rs_data", rs_data, 32'd0);
        check("r0_write.imm", imm, 32'd5);

        tick();
        wb_reg_write = 1'b0;
        settle();
        check_ctl("sw", 6'h2B, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sw.imm", imm, 32'd8);
        // SW uses rt: load to r3 in EX must stall
        ex_mem_read = 1'b1; ex_rd = 5'd3;
        #1;
        check("sw_rt_hazard.stall", {31'd0, stall}, 32'd1);
        ex_rd = 5'd0;
        #1;
        check("ex_rd_zero.stall", {31'd0, stall}, 32'd0);
        ex_mem_read = 1'b0;
        if_instr = 32'h20E8_0000;  // ADDI r8,r7,0
        tick();
        settle();
        check("r7_after_wb.rs_data", rs_data, 32'hDEAD_BEEF);
        if_instr = 32'h0043_1820;  // ADD r3,r2,r3

        tick();
        // Flush together with a hazard
        ex_mem_read = 1'b1; ex_rd = 5'd2; flush = 1'b1;
        if_instr = 32'h2085_FFFF;
        settle();
        check("flush_hazard.stall", {31'd0, stall}, 32'd1);
        tick();
        flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; if_valid = 1'b0;
        settle();
        check_ctl("post_flush", 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check("flushed_never_issues.reg_write", {31'd0, reg_write}, 32'd0);

        // Reset during a stall
        if_instr = 32'h0043_1820; if_valid = 1'b1;
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd2;
        settle();
        check("pre_reset.stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        if_instr = 32'h0027_3820;  // ADD r7,r1,r7
        settle();
        check_ctl("reset_stall", 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_stall.imm", imm, 32'd0);
        tick();
        if_valid = 1'b0;
        settle();
        check("post_reset.rs_data_r1", rs_data, 32'd0);
        check("post_reset.rt_data_r7", rt_data, 32'd0);
        check("post_reset.rd_data_r7", rd_data, 32'd0);
        check_ctl("post_reset_add", 6'h00, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
